rate_meter_multi: RTL and testbench



---
 rtl/rate_meter_pkg.sv | 19 +
 rtl/rate_meter_ch.sv | 80 ++++++++
 rtl/rate_meter_multi.sv | 172 +++++++++++++++++
 tb/tb_rate_meter_multi.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rate_meter_pkg.sv
// -----------------------------------------------------------------------------
// rate_meter_pkg
//   Shared definitions for the multi-channel gated edge-rate meter.
//   - state_e   : gate FSM state (IDLE, GATE)
//   - sel_width : width of the readout channel select, never less than 1 bit
// -----------------------------------------------------------------------------
package rate_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_e;

  // $clog2(1) is 0, which would give a zero-width select port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rate_meter_ch.sv
// -----------------------------------------------------------------------------
// rate_meter_ch
//   One channel of the rate meter: NUM_SYNC-flop synchroniser, registered
//   rising-edge detect and a saturating edge counter with an overflow bit.
//
// Ports
//   clk, rst_n : system clock, asynchronous active-low reset
//   sig_in     : asynchronous input signal
//   count_en   : high while the gate window is open
//   restart    : last cycle of a window; running state restarts from zero
//   clr        : abort; running state restarts from zero
//   cnt_fin    : running count including a pulse on the current cycle
//   ovf_fin    : running overflow including a pulse on the current cycle
// -----------------------------------------------------------------------------
module rate_meter_ch #(
  parameter int WIDTH    = 32,
  parameter int NUM_SYNC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             count_en,
  input  logic             restart,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt_fin,
  output logic             ovf_fin
);

  logic [NUM_SYNC-1:0] sync_q, sync_d;
  logic                prev_q, prev_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                pulse;

  // Synchroniser shift chain; bit 0 is the first flop after the pin.
  assign sync_d = {sync_q[NUM_SYNC-2:0], sig_in};
  assign prev_d = sync_q[NUM_SYNC-1];

  // Pulse is valid in the cycle the synchronised level first reads high, so
  // the count register reflects an input edge NUM_SYNC+1 cycles later.
  assign pulse = sync_q[NUM_SYNC-1] & ~prev_q;

  always_comb begin
    cnt_fin = cnt_q;
    ovf_fin = ovf_q;
    if (count_en && pulse) begin
      if (&cnt_q) begin
        ovf_fin = 1'b1;               // hold at all-ones, flag the lost edge
      end else begin
        cnt_fin = cnt_q + WIDTH'(1);
      end
    end
  end

  // The top latches cnt_fin on the last window cycle, so the running state
  // can restart from zero on the same edge without losing that pulse.
  always_comb begin
    cnt_d = cnt_fin;
    ovf_d = ovf_fin;
    if (clr || restart) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: rtl/rate_meter_multi.sv
// -----------------------------------------------------------------------------
// rate_meter_multi
//   Multi-channel gated edge-rate meter. Each channel counts rising edges of a
//   slow asynchronous input over a programmable gate window; all channels are
//   latched together at the end of the window.
//
// Ports
//   clk, rst_n : system clock, asynchronous active-low reset
//   sig_in     : NUM_CH asynchronous inputs
//   gate_len   : window length in clk cycles (0 behaves as 1)
//   mode       : 0 = continuous, 1 = single-shot
//   start      : single-shot trigger (ignored while a window is open)
//   clear      : abort: zero counts, results and overflow, go idle
//   busy       : high while a gate window is open
//   valid      : one-cycle pulse when new results are latched
//   ovf        : per-channel saturation flag of the latched window
//   q_all      : latched counts, channel 0 in the LSBs
//   rd_sel     : readout channel select
//   rd_data    : q_all slice for rd_sel, one cycle later (0 if out of range)
// -----------------------------------------------------------------------------
module rate_meter_multi
  import rate_meter_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int WIDTH    = 32,
  parameter  int GATE_W   = 32,
  parameter  int NUM_SYNC = 3,
  localparam int SEL_W    = sel_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       sig_in,
  input  logic [GATE_W-1:0]       gate_len,
  input  logic                    mode,
  input  logic                    start,
  input  logic                    clear,
  output logic                    busy,
  output logic                    valid,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH*WIDTH-1:0] q_all,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [WIDTH-1:0]        rd_data
);

  state_e                  state_q, state_d;
  logic [GATE_W-1:0]       gate_cnt_q, gate_cnt_d;
  logic [GATE_W-1:0]       len_m1_q, len_m1_d;   // shadowed window length - 1
  logic                    valid_q, valid_d;
  logic [NUM_CH-1:0]       ovf_q, ovf_d;
  logic [NUM_CH*WIDTH-1:0] q_all_q, q_all_d;
  logic [WIDTH-1:0]        rd_data_q, rd_data_d;

  logic [GATE_W-1:0]       len_m1_in;
  logic                    count_en;
  logic                    win_end;
  logic [WIDTH-1:0]        cnt_fin [NUM_CH];
  logic [NUM_CH-1:0]       ovf_fin;

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  assign count_en = (state_q == GATE);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    rate_meter_ch #(
      .WIDTH    (WIDTH),
      .NUM_SYNC (NUM_SYNC)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .sig_in   (sig_in[gi]),
      .count_en (count_en),
      .restart  (win_end),
      .clr      (clear),
      .cnt_fin  (cnt_fin[gi]),
      .ovf_fin  (ovf_fin[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Gate FSM and result latch
  // ---------------------------------------------------------------------------
  // A zero length is folded into a one-cycle window.
  assign len_m1_in = (gate_len == '0) ? '0 : gate_len - GATE_W'(1);

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    len_m1_d   = len_m1_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;
    q_all_d    = q_all_q;
    win_end    = 1'b0;

    if (clear) begin
      state_d    = IDLE;
      gate_cnt_d = '0;
      ovf_d      = '0;
      q_all_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!mode || start) begin
            state_d    = GATE;
            gate_cnt_d = '0;
            len_m1_d   = len_m1_in;
          end
        end
        GATE: begin
          if (gate_cnt_q == len_m1_q) begin
            // Last window cycle: cnt_fin already includes this cycle's pulse.
            win_end = 1'b1;
            valid_d = 1'b1;
            ovf_d   = ovf_fin;
            for (int i = 0; i < NUM_CH; i++) begin
              q_all_d[i*WIDTH +: WIDTH] = cnt_fin[i];
            end
            if (!mode) begin
              // Back-to-back window, no dead cycle; pick up a new length.
              gate_cnt_d = '0;
              len_m1_d   = len_m1_in;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gate_cnt_d = gate_cnt_q + GATE_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Readout mux (reads the latched results, hence one cycle behind q_all)
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_data_d = q_all_q[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      len_m1_q   <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= '0;
      q_all_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      len_m1_q   <= len_m1_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      q_all_q    <= q_all_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign busy    = (state_q == GATE);
  assign valid   = valid_q;
  assign ovf     = ovf_q;
  assign q_all   = q_all_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_rate_meter_multi.sv
// -----------------------------------------------------------------------------
// tb_rate_meter_multi
//   Directed bench: main instance (4 ch, 32-bit counts) plus a narrow
//   instance (3 ch, 4-bit counts) for saturation and out-of-range readout.
// -----------------------------------------------------------------------------
module tb_rate_meter_multi;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 32;
  localparam int GATE_W = 32;
  localparam int S_CH   = 3;
  localparam int S_W    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic [NUM_CH-1:0]       sig_in;
  logic [GATE_W-1:0]       gate_len;
  logic                    mode, start, clear;
  logic                    busy, valid;
  logic [NUM_CH-1:0]       ovf;
  logic [NUM_CH*WIDTH-1:0] q_all;
  logic [1:0]              rd_sel;
  logic [WIDTH-1:0]        rd_data;

  // narrow instance
  logic [S_CH-1:0]         sig_in_s;
  logic [GATE_W-1:0]       gate_len_s;
  logic                    mode_s, start_s, clear_s;
  logic                    busy_s, valid_s;
  logic [S_CH-1:0]         ovf_s;
  logic [S_CH*S_W-1:0]     q_all_s;
  logic [1:0]              rd_sel_s;
  logic [S_W-1:0]          rd_data_s;

  // square-wave generators: bits 3:0 feed the main instance, 6:4 the narrow one
  logic [6:0] gen_sig = '0;
  int         gen_period [7] = '{default: 0};
  logic [3:0] man_sig = '0;

  assign sig_in   = gen_sig[3:0] | man_sig;
  assign sig_in_s = gen_sig[6:4];

  rate_meter_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .GATE_W(GATE_W), .NUM_SYNC(3)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .gate_len(gate_len), .mode(mode),
    .start(start), .clear(clear), .busy(busy), .valid(valid), .ovf(ovf),
    .q_all(q_all), .rd_sel(rd_sel), .rd_data(rd_data)
  );

  rate_meter_multi #(.NUM_CH(S_CH), .WIDTH(S_W), .GATE_W(GATE_W), .NUM_SYNC(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in_s), .gate_len(gate_len_s), .mode(mode_s),
    .start(start_s), .clear(clear_s), .busy(busy_s), .valid(valid_s), .ovf(ovf_s),
    .q_all(q_all_s), .rd_sel(rd_sel_s), .rd_data(rd_data_s)
  );

  initial begin
    int ph [7];
    for (int c = 0; c < 7; c++) ph[c] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 7; c++) begin
        if (gen_period[c] == 0) begin
          gen_sig[c] = 1'b0;
          ph[c] = 0;
        end else begin
          ph[c] = (ph[c] + 1) % gen_period[c];
          gen_sig[c] = (ph[c] < gen_period[c] / 2);
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-20s got %0d exp %0d", tag, got, exp);
    end else begin
      $display("FAIL %-20s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a valid pulse; n = negedges elapsed including the hit.
  task automatic wait_valid(input bit narrow, input int max_cyc, input string tag, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      n++;
      seen = narrow ? valid_s : valid;
    end
    check({tag, "_seen"}, seen, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish exp finish");
    $fatal(1);
  end

  initial begin
    int n, busy_cnt, valid_cnt, first_busy, valid_idx, bad, sum;

    mode = 1'b0; start = 1'b0; clear = 1'b0; gate_len = 1000; rd_sel = 2'd0;
    mode_s = 1'b0; start_s = 1'b0; clear_s = 1'b0; gate_len_s = 100; rd_sel_s = 2'd2;
    gen_period[0] = 10;
    gen_period[6] = 4;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // ---- reset state
    check("rst_busy",  busy, 0);
    check("rst_valid", valid, 0);
    check("rst_q_all", |q_all, 0);
    check("rst_ovf",   ovf, 0);
    check("rst_rd",    rd_data, 0);
    rst_n = 1'b1;

    // ---- saturation on the 4-bit instance: 25 edges per 100-cycle window
    wait_valid(1'b1, 150, "sat_w1", n);
    check("sat_ch2_cnt", q_all_s[11:8], 15);
    check("sat_ovf",     ovf_s, 3'b100);
    @(negedge clk);
    check("sat_rd2", rd_data_s, 15);
    rd_sel_s = 2'd3;
    @(negedge clk);
    check("sat_rd_oob", rd_data_s, 0);
    gen_period[6] = 0;
    wait_valid(1'b1, 150, "sat_w2", n);
    wait_valid(1'b1, 150, "sat_w3", n);
    check("sat_idle_cnt", q_all_s[11:8], 0);
    check("sat_idle_ovf", ovf_s, 0);

    // ---- basic continuous count, period-10 square wave on ch0
    wait_valid(1'b0, 1100, "basic_w1", n);
    check("basic_w1_range", (q_all[31:0] >= 99 && q_all[31:0] <= 101), 1);
    wait_valid(1'b0, 1100, "basic_w2", n);
    check("basic_period", n, 1000);
    check("basic_ch0", q_all[31:0], 100);
    check("basic_ch1", q_all[63:32], 0);
    check("basic_ovf", ovf, 0);
    @(negedge clk);
    check("basic_vpulse", valid, 0);
    check("basic_rd0", rd_data, 100);

    // ---- single-shot: 50-cycle window, second start during busy ignored
    mode = 1'b1;
    wait_valid(1'b0, 1100, "ss_arm", n);
    check("ss_idle_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("ss_idle_still", busy, 0);
    gate_len = 50;
    start = 1'b1;
    busy_cnt = 0; valid_cnt = 0; first_busy = -1; valid_idx = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0 || i == 11) start = 1'b0;
      if (i == 10) start = 1'b1;
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = i;
      end
      if (valid) begin
        valid_cnt++;
        valid_idx = i;
      end
    end
    check("ss_busy_cycles", busy_cnt, 50);
    check("ss_valid_count", valid_cnt, 1);
    check("ss_first_busy",  first_busy, 0);
    check("ss_valid_idx",   valid_idx, 50);
    check("ss_ch0",         q_all[31:0], 5);

    // ---- window boundary: pulses on last cycle of W1 (ch2) and first of W2 (ch3)
    gen_period[0] = 0;
    mode = 1'b0;
    gate_len = 10;
    wait_valid(1'b0, 50, "bnd_sync", n);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 6) man_sig[2] = 1'b1;  // three sync stages -> pulse at cycle 9
      if (i == 7) man_sig[3] = 1'b1;  // -> pulse at cycle 10
      if (i == 10) begin
        check("bnd_w1_valid", valid, 1);
        check("bnd_w1_ch2", q_all[95:64], 1);
        check("bnd_w1_ch3", q_all[127:96], 0);
      end
      if (i == 20) begin
        check("bnd_w2_valid", valid, 1);
        check("bnd_w2_ch2", q_all[95:64], 0);
        check("bnd_w2_ch3", q_all[127:96], 1);
      end
    end
    man_sig = '0;

    // ---- clear at cycle 500 of a 1000-cycle window
    gate_len = 1000;
    gen_period[0] = 10;
    wait_valid(1'b0, 1100, "clr_w0", n);
    wait_valid(1'b0, 1100, "clr_w1", n);
    wait_valid(1'b0, 1100, "clr_w2", n);
    check("clr_pre_ch0", q_all[31:0], 100);
    repeat (499) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_q_all", |q_all, 0);
    check("clr_ovf",   ovf, 0);
    check("clr_busy",  busy, 0);
    check("clr_valid", valid, 0);
    wait_valid(1'b0, 1100, "clr_next", n);
    check("clr_latency", n, 1001);
    check("clr_ch0", q_all[31:0], 100);

    // ---- asynchronous reset mid-window
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("arst_busy",  busy, 0);
    check("arst_valid", valid, 0);
    check("arst_q_all", |q_all, 0);
    check("arst_ovf",   ovf, 0);
    check("arst_rd",    rd_data, 0);

    // ---- gate_len = 0 behaves as a 1-cycle window
    gate_len = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n = 0; bad = 0; sum = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid) n++;
      if (q_all[31:0] > 1) bad++;
      sum += int'(q_all[31:0]);
    end
    check("g0_valid_every", n, 100);
    check("g0_le_one", bad, 0);
    check("g0_sum", sum, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
